// File: rtl/keccak_state_sequencer.sv
// Loads a 1600-bit state lane-by-lane through the 64-bit memory view, then
// streams it back out slice-by-slice through the 25-bit view.
module keccak_state_sequencer #(
    parameter int LANES  = 25,
    parameter int SLICES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [0:63] lane_in,
    input  logic        lane_valid,
    output logic        lane_ready,
    output logic [0:24] slice_out,
    output logic        slice_valid,
    input  logic        slice_ready,
    output logic        busy,
    output logic        done,
    output logic        mode,
    output logic [4:0]  adr64,
    output logic [0:63] in64,
    output logic        w64,
    output logic        r64,
    output logic [5:0]  adr25,
    output logic        r25,
    output logic        w25,
    input  logic [0:24] out25
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_HOLD = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  li_q, li_d;
    logic [5:0]  si_q, si_d;
    logic        lane_ready_q, lane_ready_d;
    logic [0:24] slice_out_q, slice_out_d;
    logic        slice_valid_q, slice_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mode_q, mode_d;
    logic [4:0]  adr64_q, adr64_d;
    logic [0:63] in64_q, in64_d;
    logic        w64_q, w64_d;
    logic [5:0]  adr25_q, adr25_d;
    logic        r25_q, r25_d;

    // Next-state and next-output logic; every output flop is loaded with the value for the state being entered.
    always_comb begin
        state_d       = state_q;
        li_d          = li_q;
        si_d          = si_q;
        lane_ready_d  = 1'b0;
        slice_out_d   = slice_out_q;
        slice_valid_d = slice_valid_q;
        done_d        = 1'b0;
        mode_d        = mode_q;
        adr64_d       = adr64_q;
        in64_d        = in64_q;
        w64_d         = 1'b0;
        adr25_d       = adr25_q;
        r25_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    li_d         = 5'd0;
                    lane_ready_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (lane_valid && lane_ready_q) begin
                    state_d = S_WR;
                    in64_d  = lane_in;
                    adr64_d = li_q;
                    w64_d   = 1'b1;
                end else begin
                    lane_ready_d = 1'b1;
                end
            end
            S_WR: begin
                if (li_q == 5'(LANES - 1)) begin
                    state_d = S_RD;
                    si_d    = 6'd0;
                    adr25_d = 6'd0;
                    r25_d   = 1'b1;
                    mode_d  = 1'b1;
                end else begin
                    state_d      = S_LOAD;
                    li_d         = li_q + 5'd1;
                    lane_ready_d = 1'b1;
                end
            end
            S_RD: begin
                // out25 is valid now because r25/adr25/mode were registered on entry
                state_d       = S_HOLD;
                slice_out_d   = out25;
                slice_valid_d = 1'b1;
            end
            S_HOLD: begin
                if (slice_valid_q && slice_ready) begin
                    slice_valid_d = 1'b0;
                    if (si_q == 6'(SLICES - 1)) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD;
                        si_d    = si_q + 6'd1;
                        adr25_d = si_q + 6'd1;
                        r25_d   = 1'b1;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                mode_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                mode_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, index and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            li_q          <= 5'd0;
            si_q          <= 6'd0;
            lane_ready_q  <= 1'b0;
            slice_out_q   <= 25'd0;
            slice_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mode_q        <= 1'b0;
            adr64_q       <= 5'd0;
            in64_q        <= 64'd0;
            w64_q         <= 1'b0;
            adr25_q       <= 6'd0;
            r25_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            li_q          <= li_d;
            si_q          <= si_d;
            lane_ready_q  <= lane_ready_d;
            slice_out_q   <= slice_out_d;
            slice_valid_q <= slice_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mode_q        <= mode_d;
            adr64_q       <= adr64_d;
            in64_q        <= in64_d;
            w64_q         <= w64_d;
            adr25_q       <= adr25_d;
            r25_q         <= r25_d;
        end
    end

    assign lane_ready  = lane_ready_q;
    assign slice_out   = slice_out_q;
    assign slice_valid = slice_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mode        = mode_q;
    assign adr64       = adr64_q;
    assign in64        = in64_q;
    assign w64         = w64_q;
    assign adr25       = adr25_q;
    assign r25         = r25_q;
    assign r64         = 1'b0;
    assign w25         = 1'b0;

endmodule

// File: tb/tb_keccak_state_sequencer.sv
// Scenario-table bench for keccak_state_sequencer with a dual-view state memory
// stand-in and expected slices derived by transposing the loaded lanes.
module tb_keccak_state_sequencer;

    localparam int LANES  = 25;
    localparam int SLICES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [0:63] lane_in;
    logic        lane_valid;
    logic        lane_ready;
    logic [0:24] slice_out;
    logic        slice_valid;
    logic        slice_ready;
    logic        busy;
    logic        done;
    logic        mode;
    logic [4:0]  adr64;
    logic [0:63] in64;
    logic        w64;
    logic        r64;
    logic [5:0]  adr25;
    logic        r25;
    logic        w25;
    logic [0:24] out25;

    logic [0:63] mem       [0:LANES-1];
    logic [0:63] lane_data [0:LANES-1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int pattern;      // 0: {8{k}}, 1: lane3 = ..FF55 with lanes 0-2 zero, 2: random
        int lane_gap;     // idle cycles of lane_valid after each accepted lane
        int stall_slice;  // slice index held with slice_ready=0
        int stall_len;
        int start_noise;  // toggle start while busy
        int rand_hs;      // random lane_valid / slice_ready
        int exp_cycles;   // start edge to done; -1 = 179 + observed wait cycles
    } scen_t;

    scen_t tbl [0:4];

    keccak_state_sequencer #(.LANES(LANES), .SLICES(SLICES)) dut (
        .clk(clk), .rst(rst), .start(start),
        .lane_in(lane_in), .lane_valid(lane_valid), .lane_ready(lane_ready),
        .slice_out(slice_out), .slice_valid(slice_valid), .slice_ready(slice_ready),
        .busy(busy), .done(done), .mode(mode),
        .adr64(adr64), .in64(in64), .w64(w64), .r64(r64),
        .adr25(adr25), .r25(r25), .w25(w25), .out25(out25)
    );

    always #5 clk = ~clk;

    // Lane-view write port of the state memory.
    always @(posedge clk) begin
        if (w64 && adr64 < 5'd25) mem[adr64] <= in64;
    end

    // Slice-view read port: slice z gathers bit z of every lane.
    always_comb begin
        out25 = '0;
        if (r25 && mode) begin
            for (int x = 0; x < LANES; x++) out25[x] = mem[x][adr25];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [0:24] exp_slice(input int z);
        logic [0:24] r;
        for (int x = 0; x < LANES; x++) r[x] = lane_data[x][z];
        return r;
    endfunction

    task automatic run_scenario(input scen_t s, input int idx);
        int li, ns, nw, nr, ndone, done_cyc, cyc, stalls, gap_left, stall_cnt, exp_cyc;
        logic hs_lane, hs_slice, prev_hold;
        logic [0:24] prev_out;
        logic [5:0] prev_adr;
        li = 0; ns = 0; nw = 0; nr = 0; ndone = 0; done_cyc = -1; cyc = 0;
        stalls = 0; gap_left = 0; stall_cnt = 0;
        prev_hold = 1'b0; prev_out = '0; prev_adr = '0;
        for (int k = 0; k < LANES; k++) begin
            case (s.pattern)
                0:       lane_data[k] = {8{8'(k)}};
                1:       lane_data[k] = (k < 3) ? 64'd0 : (k == 3) ? 64'hFFFF_FFFF_FFFF_FF55
                                                                   : {$urandom, $urandom};
                default: lane_data[k] = {$urandom, $urandom};
            endcase
        end
        @(posedge clk); #1;
        start       = 1'b1;
        lane_valid  = (s.rand_hs != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        lane_in     = lane_data[0];
        slice_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (cyc > 0) begin
                chk($sformatf("s%0d_w25_r64_zero", idx), {62'd0, w25, r64}, 64'd0);
                chk($sformatf("s%0d_w64_r25_excl", idx), 64'(w64 & r25), 64'd0);
                if (w64) begin
                    if (nw < LANES) begin
                        chk($sformatf("s%0d_adr64", idx), 64'(adr64), 64'(nw));
                        chk($sformatf("s%0d_in64", idx), in64, lane_data[nw]);
                        chk($sformatf("s%0d_w64_mode", idx), 64'(mode), 64'd0);
                    end else begin
                        chk($sformatf("s%0d_extra_w64", idx), 64'(nw), 64'(LANES - 1));
                    end
                    nw++;
                end
                if (r25) begin
                    chk($sformatf("s%0d_adr25", idx), 64'(adr25), 64'(nr));
                    chk($sformatf("s%0d_r25_mode", idx), 64'(mode), 64'd1);
                    nr++;
                end
                if (prev_hold) begin
                    chk($sformatf("s%0d_hold_valid", idx), 64'(slice_valid), 64'd1);
                    chk($sformatf("s%0d_hold_data", idx), 64'(slice_out), 64'(prev_out));
                    chk($sformatf("s%0d_hold_adr25", idx), 64'(adr25), 64'(prev_adr));
                end
                if (done) begin
                    ndone++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
            end
            hs_lane  = lane_valid && lane_ready;
            hs_slice = slice_valid && slice_ready;
            if (lane_ready && !lane_valid) stalls++;
            if (slice_valid && !slice_ready) stalls++;
            if (hs_slice) begin
                if (ns < SLICES) chk($sformatf("s%0d_slice%0d", idx, ns), 64'(slice_out), 64'(exp_slice(ns)));
                else chk($sformatf("s%0d_extra_slice", idx), 64'(ns), 64'(SLICES - 1));
                ns++;
            end
            if (hs_lane) begin
                li++;
                gap_left = s.lane_gap;
            end
            prev_hold = slice_valid && !slice_ready;
            prev_out  = slice_out;
            prev_adr  = adr25;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
            cyc++;
            start = (s.start_noise != 0 && busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gap_left > 0) begin
                lane_valid = 1'b0;
                gap_left--;
            end else if (li < LANES) begin
                lane_valid = (s.rand_hs != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                lane_valid = 1'b0;
            end
            lane_in = lane_data[(li < LANES) ? li : 0];
            if (s.rand_hs != 0) begin
                slice_ready = 1'($urandom_range(0, 1));
            end else if (slice_valid && ns == s.stall_slice && stall_cnt < s.stall_len) begin
                slice_ready = 1'b0;
                stall_cnt++;
            end else begin
                slice_ready = 1'b1;
            end
        end
        exp_cyc = (s.exp_cycles >= 0) ? s.exp_cycles : 179 + stalls;
        chk($sformatf("s%0d_done_cycle", idx), 64'(done_cyc), 64'(exp_cyc));
        chk($sformatf("s%0d_done_count", idx), 64'(ndone), 64'd1);
        chk($sformatf("s%0d_w64_count", idx), 64'(nw), 64'(LANES));
        chk($sformatf("s%0d_r25_count", idx), 64'(nr), 64'(SLICES));
        chk($sformatf("s%0d_slice_count", idx), 64'(ns), 64'(SLICES));
        chk($sformatf("s%0d_lane_count", idx), 64'(li), 64'(LANES));
        chk($sformatf("s%0d_end_busy", idx), 64'(busy), 64'd0);
        chk($sformatf("s%0d_end_mode", idx), 64'(mode), 64'd0);
        start      = 1'b0;
        lane_valid = 1'b0;
    endtask

    initial begin
        int found;
        rst = 1'b1; start = 1'b0; lane_valid = 1'b0; lane_in = '0; slice_ready = 1'b0;
        tbl[0] = '{pattern: 0, lane_gap: 0, stall_slice: -1, stall_len: 0, start_noise: 0, rand_hs: 0, exp_cycles: 179};
        tbl[1] = '{pattern: 1, lane_gap: 0, stall_slice: -1, stall_len: 0, start_noise: 0, rand_hs: 0, exp_cycles: 179};
        tbl[2] = '{pattern: 2, lane_gap: 2, stall_slice: 10, stall_len: 5, start_noise: 0, rand_hs: 0, exp_cycles: 208};
        tbl[3] = '{pattern: 2, lane_gap: 0, stall_slice: -1, stall_len: 0, start_noise: 1, rand_hs: 0, exp_cycles: 179};
        tbl[4] = '{pattern: 2, lane_gap: 0, stall_slice: -1, stall_len: 0, start_noise: 1, rand_hs: 1, exp_cycles: -1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_lane_ready", 64'(lane_ready), 64'd0);
        chk("rst_slice_valid", 64'(slice_valid), 64'd0);
        chk("rst_slice_out", 64'(slice_out), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mode", 64'(mode), 64'd0);
        chk("rst_adr64", 64'(adr64), 64'd0);
        chk("rst_in64", in64, 64'd0);
        chk("rst_adr25", 64'(adr25), 64'd0);
        chk("rst_strobes", {60'd0, w64, r64, r25, w25}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_scenario(tbl[i], i);

        // Abort with reset while lane 12 is being written, then restart from lane 0.
        @(posedge clk); #1;
        for (int k = 0; k < LANES; k++) lane_data[k] = {8{8'(k)}};
        start = 1'b1; lane_valid = 1'b1; lane_in = lane_data[0]; slice_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (w64 && adr64 == 5'd12) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("midrst_reach_lane12", 64'(found), 64'd1);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("midrst_w64", 64'(w64), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_lane_ready", 64'(lane_ready), 64'd0);
        chk("midrst_adr64", 64'(adr64), 64'd0);
        rst = 1'b0; lane_valid = 1'b0;
        run_scenario(tbl[0], 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
